mem_arbiter_ctrl: RTL and testbench



---
 rtl/mem_arbiter_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: registered-grant arbiter giving the single-ported RAM to the icache or the dcache.
// Latency: request seen in IDLE -> RAM strobe next cycle -> owner wait drops in the first ACCESS cycle -> IDLE.
// Backpressure: owner stalls (wait high) while RAM is FREE/BUSY/ERROR; the non-owner always stalls.
// Ports: CLK/RST; iREN/iaddr and dREN/dWEN/daddr/dstore requests; ramload/ramstate from the RAM;
//        iwait/iload and dwait/dload back to the caches; ramREN/ramWEN/ramaddr/ramstore to the RAM.
// Optional feature macro: MEM_ARB_FAIRNESS_EN (data-streak limit so a waiting fetch eventually wins).
module mem_arbiter_ctrl #(
  parameter int WORD_W       = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   fetch_force;
  logic   i_done, d_done;

  // Completion needs the owner to still be requesting; a withdrawn request never sees a pulse.
  assign i_done = (state_q == IFETCH) && iREN && (ramstate == RAM_ACCESS);
  assign d_done = (((state_q == DREAD) && dREN) || ((state_q == DWRITE) && dWEN))
                  && (ramstate == RAM_ACCESS);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;

  assign fetch_force = iREN && (streak_q == STREAK_MAX);

  // Counts data grants taken while a fetch is waiting; only moves in IDLE.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (!iREN || (state_d == IFETCH)) begin
        streak_d = '0;
      end else if ((state_d != IDLE) && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  // Strict data-over-instruction priority.
  assign fetch_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_force)  state_d = IFETCH;
        else if (dWEN)    state_d = DWRITE;  // write wins when dREN is also high
        else if (dREN)    state_d = DREAD;
        else if (iREN)    state_d = IFETCH;
      end
      IFETCH: if (!iREN || (ramstate == RAM_ACCESS)) state_d = IDLE;
      DREAD:  if (!dREN || (ramstate == RAM_ACCESS)) state_d = IDLE;
      DWRITE: if (!dWEN || (ramstate == RAM_ACCESS)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM port follows the owner's live inputs; ERROR simply leaves the access asserted for a retry.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = !i_done;
  assign dwait = !d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: randomized and directed stimulus against a cycle reference model with a scoreboard.
// Latency: expected outputs are queued right after each edge and popped by the monitor at the next negedge.
// Backpressure: the bench plays both caches and the RAM, driving ramstate freely every cycle.
module tb_mem_arbiter_ctrl;

  localparam int W    = 32;
  localparam int SMAX = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam int OWN_NONE = 0, OWN_I = 1, OWN_DR = 2, OWN_DW = 3;

  logic         CLK = 1'b0;
  logic         RST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic [1:0]   ramstate;
  logic         iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter_ctrl #(.WORD_W(W), .D_STREAK_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ramstate(ramstate),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  typedef struct packed {
    logic         iw;
    logic         dw;
    logic [W-1:0] il;
    logic [W-1:0] dl;
    logic         rren;
    logic         rwen;
    logic [W-1:0] raddr;
    logic [W-1:0] rstore;
  } out_t;

  out_t sbq[$];
  int   n_checks = 0, n_errors = 0;
  int   i_done_cnt = 0, d_done_cnt = 0;
  int   m_own = OWN_NONE;   // which requester the model says holds the RAM
  int   m_streak = 0;       // data grants taken while a fetch waited

  function automatic bit owner_req();
    case (m_own)
      OWN_I:   return iREN;
      OWN_DR:  return dREN;
      OWN_DW:  return dWEN;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_step();
    int win;
    if (RST) begin
      m_own    = OWN_NONE;
      m_streak = 0;
    end else if (m_own == OWN_NONE) begin
      win = OWN_NONE;
      if (FAIR && iREN && (m_streak == SMAX)) win = OWN_I;
      else if (dWEN)                          win = OWN_DW;
      else if (dREN)                          win = OWN_DR;
      else if (iREN)                          win = OWN_I;
      if (!iREN || (win == OWN_I))                  m_streak = 0;
      else if ((win != OWN_NONE) && (m_streak < SMAX)) m_streak = m_streak + 1;
      m_own = win;
    end else if (!owner_req() || (ramstate == RS_ACCESS)) begin
      m_own = OWN_NONE;
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    e    = '0;
    e.iw = 1'b1;
    e.dw = 1'b1;
    case (m_own)
      OWN_I:  begin e.rren = 1'b1; e.raddr = iaddr; end
      OWN_DR: begin e.rren = 1'b1; e.raddr = daddr; end
      OWN_DW: begin e.rwen = 1'b1; e.raddr = daddr; e.rstore = dstore; end
      default: ;
    endcase
    if ((m_own != OWN_NONE) && owner_req() && (ramstate == RS_ACCESS)) begin
      if (m_own == OWN_I) begin e.iw = 1'b0; e.il = ramload; end
      else                begin e.dw = 1'b0; e.dl = ramload; end
    end
    return e;
  endfunction

  // One bench cycle: step the model at the edge, apply new inputs, queue the expected outputs.
  task automatic cyc(input logic rst, input logic i, input logic dr, input logic dw,
                     input logic [1:0] rs, input logic [W-1:0] ia, input logic [W-1:0] da,
                     input logic [W-1:0] ds, input logic [W-1:0] rl);
    @(posedge CLK);
    model_step();
    #1;
    RST = rst; iREN = i; dREN = dr; dWEN = dw; ramstate = rs;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    sbq.push_back(model_out());
  endtask

  task automatic idle_cyc(input logic [1:0] rs);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rs, '0, '0, '0, '0);
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected record per cycle and compares the full output set.
  initial begin
    out_t e, a;
    forever begin
      @(negedge CLK);
      a = {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore};
      if (iwait === 1'b0) i_done_cnt++;
      if (dwait === 1'b0) d_done_cnt++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t got iw=%b dw=%b il=%h dl=%h ren=%b wen=%b addr=%h st=%h, expected iw=%b dw=%b il=%h dl=%h ren=%b wen=%b addr=%h st=%h",
                   $time, a.iw, a.dw, a.il, a.dl, a.rren, a.rwen, a.raddr, a.rstore,
                   e.iw, e.dw, e.il, e.dl, e.rren, e.rwen, e.raddr, e.rstore);
        end
      end
    end
  end

  initial begin
    int i0, d0;
    logic ri, rdr, rdw, rrst;
    logic [1:0] rs;
    int p;

    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

    // Reset held two cycles, then five quiet idle cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, RS_FREE, '0, '0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, RS_FREE, '0, '0, '0, '0);
    repeat (5) idle_cyc(RS_FREE);

    // Single fetch, RAM answers on the third granted cycle.
    settle(); i0 = i_done_cnt;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_FREE,   32'h100, '0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_BUSY,   32'h100, '0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_BUSY,   32'h100, '0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_ACCESS, 32'h100, '0, '0, 32'hDEADBEEF);
    idle_cyc(RS_FREE);
    settle();
    check_int("single_fetch_completions", i_done_cnt - i0, 1);

    // Fetch and write together: write first, fetch after one IDLE cycle.
    i0 = i_done_cnt; d0 = d_done_cnt;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, RS_ACCESS, 32'h200, 32'h40, 32'h12345678, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, RS_ACCESS, 32'h200, 32'h40, 32'h12345678, 32'hA5A5A5A5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_ACCESS, 32'h200, 32'h40, 32'h12345678, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_ACCESS, 32'h200, 32'h40, 32'h12345678, 32'h0BADF00D);
    idle_cyc(RS_FREE);
    settle();
    check_int("contention_write_completions", d_done_cnt - d0, 1);
    check_int("contention_fetch_completions", i_done_cnt - i0, 1);

    // ERROR twice during a read, then ACCESS.
    d0 = d_done_cnt;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_FREE,   '0, 32'h80, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_ERROR,  '0, 32'h80, '0, 32'h11111111);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_ERROR,  '0, 32'h80, '0, 32'h22222222);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_ACCESS, '0, 32'h80, '0, 32'h55AA55AA);
    idle_cyc(RS_FREE);
    settle();
    check_int("error_retry_completions", d_done_cnt - d0, 1);

    // Read withdrawn mid-transaction: no completion even though ACCESS shows up.
    d0 = d_done_cnt;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_FREE,   '0, 32'hC0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, RS_BUSY,   '0, 32'hC0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, RS_ACCESS, '0, 32'hC0, '0, 32'h77777777);
    idle_cyc(RS_FREE);
    settle();
    check_int("withdrawal_completions", d_done_cnt - d0, 0);

    // Reset in the middle of a fetch aborts it.
    i0 = i_done_cnt;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_FREE, 32'h300, '0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, RS_BUSY, 32'h300, '0, '0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, RS_BUSY, 32'h300, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, RS_ACCESS, 32'h300, '0, '0, 32'h99999999);
    idle_cyc(RS_FREE);
    settle();
    check_int("reset_abort_completions", i_done_cnt - i0, 0);

    // Fetch held high under continuous reads with a zero-wait RAM for 40 cycles.
    i0 = i_done_cnt; d0 = d_done_cnt;
    repeat (40) cyc(1'b0, 1'b1, 1'b1, 1'b0, RS_ACCESS, $urandom, $urandom, $urandom, $urandom);
    idle_cyc(RS_FREE);
    settle();
    check_int("fairness_fetch_completions", i_done_cnt - i0, FAIR ? 4 : 0);
    check_int("fairness_read_completions",  d_done_cnt - d0, FAIR ? 16 : 20);

    // Random traffic: sticky requests that occasionally toggle, random RAM state and rare resets.
    i0 = i_done_cnt; d0 = d_done_cnt;
    ri = 1'b0; rdr = 1'b0; rdw = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 15) ri  = ~ri;
      if ($urandom_range(0, 99) < 15) rdr = ~rdr;
      if ($urandom_range(0, 99) < 10) rdw = ~rdw;
      p  = int'($urandom_range(0, 99));
      rs = (p < 40) ? RS_ACCESS : (p < 65) ? RS_BUSY : (p < 80) ? RS_FREE : RS_ERROR;
      rrst = ($urandom_range(0, 299) == 0);
      cyc(rrst, ri, rdr, rdw, rs, $urandom, $urandom, $urandom, $urandom);
    end
    idle_cyc(RS_FREE);
    settle();
    check_int("random_fetch_seen", int'(i_done_cnt > i0), 1);
    check_int("random_data_seen",  int'(d_done_cnt > d0), 1);
    check_int("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
